// File: rtl/lsu_mem_if.sv
// lsu_mem_if: MEM-stage load/store unit driving a word-wide
// req/gnt/rvalid data bus with byte enables and load extension.
module lsu_mem_if #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        acc;
  logic        legal;
  logic [3:0]  be_nx;
  logic [31:0] wd_nx;
  logic [2:0]  type_q;
  logic [1:0]  off_q;
  logic [31:0] lane;
  logic [31:0] ld_ext;

  assign req_ready  = (state == S_IDLE);
  assign acc        = req_valid & req_ready;
  assign busy       = (req_valid & ~req_ready)
                    | (state != S_IDLE);
  assign mem_req    = (state == S_REQ);
  assign resp_valid = (state == S_RESP);

  // Unsigned types are load-only; stores of them are illegal.
  always_comb begin
    legal = 1'b0;
    be_nx = 4'b0000;
    wd_nx = req_wdata;
    unique case (req_type)
      DM_W: begin
        legal = (req_addr[1:0] == 2'b00);
        be_nx = 4'b1111;
      end
      DM_H, DM_HU: begin
        legal = ~req_addr[0]
              & ~(req_we & (req_type == DM_HU));
        be_nx = 4'b0011 << {req_addr[1], 1'b0};
        wd_nx = {2{req_wdata[15:0]}};
      end
      DM_B, DM_BU: begin
        legal = ~(req_we & (req_type == DM_BU));
        be_nx = 4'b0001 << req_addr[1:0];
        wd_nx = {4{req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    lane   = mem_rdata >> {off_q, 3'b000};
    ld_ext = lane;
    unique case (1'b1)
      type_q == DM_H:
        ld_ext = {{16{lane[15]}}, lane[15:0]};
      type_q == DM_HU:
        ld_ext = {16'h0000, lane[15:0]};
      type_q == DM_B:
        ld_ext = {{24{lane[7]}}, lane[7:0]};
      type_q == DM_BU:
        ld_ext = {24'h000000, lane[7:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (acc)
          state_nx = legal ? S_REQ : S_RESP;
      S_REQ:
        if (mem_gnt)
          state_nx = mem_we ? S_RESP : S_WAIT;
      S_WAIT:
        if (mem_rvalid)
          state_nx = S_RESP;
      S_RESP:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      type_q     <= '0;
      off_q      <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      resp_rd    <= '0;
    end else if (acc) begin
      type_q     <= req_type;
      off_q      <= req_addr[1:0];
      mem_we     <= req_we & legal;
      mem_be     <= legal ? be_nx : 4'b0000;
      mem_addr   <= req_addr[ADDR_W-1:2];
      mem_wdata  <= legal ? wd_nx : 32'h0;
      resp_err   <= ~legal;
      resp_rdata <= '0;
      resp_rd    <= req_rd;
    end else if ((state == S_WAIT) && mem_rvalid) begin
      resp_rdata <= ld_ext;
    end
  end

endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store unit that sits in the PCPU MEM stage and acts as the initiator toward word-organised data memory. It accepts one load or store per transaction from the pipeline and checks alignment. It converts byte/halfword accesses into word-addressed bus transactions with byte enables and lane-replicated write data, then returns sign- or zero-extended load data. It owns the request/grant/rvalid handshake to memory and holds the pipeline via `busy` until the access completes.

## Interface
- `ADDR_W`, default 32: byte-address width from the pipeline.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  pipeline presents an access.
- `req_ready`  out  1  high only in IDLE; transfer on `req_valid & req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_type`  in  3  access type, DMType encoding: word 0, halfword 1, halfword_unsigned 2, byte 3, byte_unsigned 4.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `req_rd`  in  5  destination register tag, echoed on the response.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_rd`  out  5  echoed tag.
- `resp_err`  out  1  misaligned or illegal type; valid with `resp_valid`.
- `busy`  out  1  `req_valid & ~req_ready` OR state ≠ IDLE; pipeline stall.
- `mem_req`  out  1  bus request; held until `mem_gnt`.
- `mem_gnt`  in  1  memory accepts request this cycle.
- `mem_we`  out  1  bus write.
- `mem_be`  out  4  byte enables.
- `mem_addr`  out  ADDR_W-2  word address (`addr[ADDR_W-1:2]`).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  32  raw memory word.

## Operation
- States: IDLE, REQ, WAIT, RESP. Reset → IDLE.
- IDLE: on handshake, latch we, type, addr, wdata, rd.
  - Legal and aligned access → REQ.
  - Otherwise → RESP with error.
- Alignment rules:
  - Word needs `addr[1:0]==0`.
  - Halfword (signed or unsigned) needs `addr[0]==0`.
  - Byte is always aligned.
  - Types 5–7 are illegal.
  - Stores with type 2 or 4 are illegal.
- Error path: no bus activity; `resp_err=1`, `resp_rdata=0`.
- Byte enables:
  - Word: `4'b1111`.
  - Halfword: `4'b0011 << addr[1]*2`.
  - Byte: `4'b0001 << addr[1:0]`.
  - Loads drive the same enables.
- Write data:
  - Word: wdata.
  - Halfword: `{2{wdata[15:0]}}`.
  - Byte: `{4{wdata[7:0]}}`.
- REQ: `mem_req=1` with `mem_we/be/addr/wdata` stable until `mem_gnt`.
  - Store granted → RESP.
  - Load granted → WAIT.
- WAIT: on `mem_rvalid`, register `mem_rdata`, then → RESP.
  - Load data extraction selects the lane by `addr[1:0]`.
  - Types 1 and 3 sign-extend from bit 15 or bit 7.
  - Types 2 and 4 zero-extend.
- RESP: `resp_valid=1` for exactly one cycle, then → IDLE. No back-pressure on the response.
- `mem_rvalid` outside WAIT is ignored. `mem_gnt` outside REQ is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req`, `mem_we`, `resp_valid`, `resp_err` = 0.
  - `mem_be`, `mem_addr`, `mem_wdata`, `resp_rdata`, `resp_rd` = 0.
  - `req_ready` = 1, `busy` = 0.
  - Requests are not accepted while `rstn` is low.
- Handshake accepted in cycle T:
  - `mem_req` rises at T+1 (registered).
  - Store with grant at T+1 → `resp_valid` at T+2.
  - Load with grant at T+1 and rvalid at T+2 → `resp_valid` at T+3. This is the minimum load latency.
  - Each grant or rvalid stall cycle adds one cycle.
- Error path: `resp_valid` at T+1.
- Memory must not assert `mem_rvalid` in the same cycle as `mem_gnt`.
- Next request is accepted no earlier than the cycle after `resp_valid`; `req_ready` returns high in that cycle. Back-to-back word loads therefore have a 4-cycle minimum period.
- Reset mid-transaction: the outstanding access is abandoned and `mem_req` drops immediately (async). A late `mem_rvalid` after reset is ignored.

## Test plan
- Word store to 0x40 with data 0xDEADBEEF, `mem_gnt` tied high:
  - Bus shows `mem_addr`=0x10, `mem_be`=1111, `mem_wdata`=0xDEADBEEF.
  - `resp_valid` 2 cycles after accept, `resp_err`=0.
- Byte store of 0x5A to 0x43:
  - `mem_be`=1000, `mem_wdata`=0x5A5A5A5A.
- Memory word 0x8001F0FF loads:
  - Signed byte at offset 3 → 0xFFFFFF80.
  - Unsigned byte at offset 3 → 0x00000080.
  - Signed halfword at offset 2 → 0xFFFF8001.
  - Unsigned halfword at offset 0 → 0x0000F0FF.
- Word load at 0x42:
  - No `mem_req` ever asserted.
  - `resp_err`=1 and `resp_rdata`=0 at T+1.
- Store with type 4 → illegal: no `mem_req`, `resp_err`=1 at T+1.
- Grant withheld 3 cycles, then rvalid 2 cycles later:
  - Bus outputs stable throughout.
  - `busy` stays high.
  - `resp_valid` at T+7 with `resp_rd` echoed.
- `rstn` pulsed low while in WAIT:
  - `mem_req`, `resp_valid` and `busy` go to 0 immediately.
  - A subsequent stray `mem_rvalid` produces no response.
